pd_stage: RTL and testbench
===========================

PD_STAGE -- requirements
Module: pd_stage

Interface
REQ-001 SHALL provide parameter: DEPTH, 4, queue entries; power of two, 2..16.
REQ-002 SHALL provide port: clk  input  1  sole clock, rising-edge.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: if_valid  input  1  fetch presents an instruction this cycle.
REQ-005 SHALL provide port: if_pc  input  32  PC of fetched instruction.
REQ-006 SHALL provide port: if_inst  input  32  fetched instruction word.
REQ-007 SHALL provide port: if_ready  output  1  queue can accept a push this cycle.
REQ-008 SHALL provide port: stall  input  1  downstream pd/id register holding; no pop.
REQ-009 SHALL provide port: refresh  input  1  pipeline flush (exception/ERET/mispredict).
REQ-010 SHALL provide port: pd_valid  output  1  head entry present.
REQ-011 SHALL provide port: pd_pc  output  32  head PC.
REQ-012 SHALL provide port: pd_inst  output  32  head instruction.
REQ-013 SHALL provide port: pd_bd  output  1  head is a branch delay slot.
REQ-014 SHALL provide port: pd_jump  output  1  head is a branch/jump.

Function
REQ-015 SHALL hold DEPTH entries {pc, inst, bd, jump}, write/read pointers wrapping modulo DEPTH, occupancy count 0..DEPTH.
REQ-016 SHALL drive if_ready = (count != DEPTH), combinational; a pop in the same cycle does not raise if_ready.
REQ-017 SHALL push on rising edge when if_valid && if_ready && !refresh; if_valid while !if_ready is ignored (fetch holds it).
REQ-018 SHALL pop on rising edge when pd_valid && !stall && !refresh.
REQ-019 SHALL allow simultaneous push and pop; count unchanged, both pointers advance.
REQ-020 SHALL drive pd_valid = (count != 0); pd_* fields combinational from head entry; when count == 0, pd_pc, pd_inst, pd_bd, pd_jump SHALL be 0.
REQ-021 SHALL give latency 1: instruction pushed at edge N appears on pd_* in cycle after N when queue was empty; no same-cycle bypass.
REQ-022 SHALL compute jump at push from if_inst: opcode 000010 J, 000011 JAL, 000100 BEQ, 000101 BNE, 000110 BLEZ, 000111 BGTZ; opcode 000001 with rt in {00000, 00001, 10000, 10001}; opcode 000000 with funct 001000 JR or 001001 JALR; all else 0.
REQ-023 SHALL keep register last_jump = jump bit of most recent push; entry bd = last_jump at its push.
REQ-024 SHALL clear last_jump on reset and refresh; first push after either has bd = 0.
REQ-025 SHALL, on refresh, clear count, both pointers and last_jump at that edge; refresh overrides any same-cycle push and pop; pd_valid = 0 the following cycle.
REQ-026 SHALL leave stored entries unchanged while stall = 1; pd_* stable for stall duration unless refresh.
REQ-027 SHALL not push or pop when an entry is in neither condition; no overflow or underflow is reachable.

Reset
REQ-028 SHALL, while reset = 1 at a rising edge, clear count, pointers and last_jump; reset overrides refresh, push and pop.
REQ-029 SHALL present after reset: pd_valid = 0, pd_pc = 0, pd_inst = 0, pd_bd = 0, pd_jump = 0, if_ready = 1.
REQ-030 SHALL not require reset of storage array contents; empty-state gating (REQ-020) masks them.

Verification
REQ-031 SHALL cover: reset, then push pc 0xBFC00000 inst 0x24080001 (addiu) -> next cycle pd_valid = 1, pd_pc = 0xBFC00000, pd_jump = 0, pd_bd = 0.
REQ-032 SHALL cover: push BEQ 0x11000003 at 0x100 then nop at 0x104, stall = 0 -> head 0x100 jump = 1 bd = 0; next head 0x104 jump = 0 bd = 1.
REQ-033 SHALL cover: stall = 1, push 5 words with DEPTH = 4 -> if_ready = 0 after 4th push, 5th held; stall released -> pops in order, 5th accepted once count < 4.
REQ-034 SHALL cover: queue 3 entries, last pushed JR 0x03E00008, refresh with if_valid = 1 -> next cycle pd_valid = 0, count 0; next push has bd = 0.
REQ-035 SHALL cover: full queue, stall = 0, if_valid = 1 -> same-cycle pop only, if_ready = 0 that cycle, count 3 after edge; pointers wrap past DEPTH - 1 without order loss.
REQ-036 SHALL cover: reset asserted with refresh, if_valid and pops active mid-stream -> all outputs match REQ-029 next cycle.

Source files
------------

// File: rtl/pd_stage.sv
// Pre-decode instruction queue between fetch and decode. Tags each entry with
// jump (branch/jump opcode) and bd (entry follows a jump, i.e. delay slot).
module pd_stage #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        if_ready,
  input  logic        stall,
  input  logic        refresh,
  output logic        pd_valid,
  output logic [31:0] pd_pc,
  output logic [31:0] pd_inst,
  output logic        pd_bd,
  output logic        pd_jump
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            last_jump_q, last_jump_d;

  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] inst_mem_q [DEPTH];
  logic        bd_mem_q   [DEPTH];
  logic        jump_mem_q [DEPTH];

  logic       push, pop, if_jump;
  logic [5:0] opcode, funct;
  logic [4:0] rt;

  assign opcode = if_inst[31:26];
  assign rt     = if_inst[20:16];
  assign funct  = if_inst[5:0];

  // Branch/jump classification of the incoming word.
  always_comb begin
    if_jump = 1'b0;
    case (opcode)
      6'b000010, 6'b000011, 6'b000100,
      6'b000101, 6'b000110, 6'b000111: if_jump = 1'b1;
      6'b000001: if_jump = (rt == 5'b00000) || (rt == 5'b00001) ||
                           (rt == 5'b10000) || (rt == 5'b10001);
      6'b000000: if_jump = (funct == 6'b001000) || (funct == 6'b001001);
      default:   if_jump = 1'b0;
    endcase
  end

  assign if_ready = (count_q != CntW'(DEPTH));
  assign pd_valid = (count_q != '0);
  assign push     = if_valid && if_ready && !refresh;
  assign pop      = pd_valid && !stall && !refresh;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_jump_d = last_jump_q;
    if (refresh) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      last_jump_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d    = wr_ptr_q + PtrW'(1);
        last_jump_d = if_jump;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_jump_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_jump_q <= last_jump_d;
    end
  end

  // Storage is not reset; empty-state gating on the outputs hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= if_pc;
      inst_mem_q[wr_ptr_q] <= if_inst;
      bd_mem_q[wr_ptr_q]   <= last_jump_q;
      jump_mem_q[wr_ptr_q] <= if_jump;
    end
  end

  assign pd_pc   = pd_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign pd_inst = pd_valid ? inst_mem_q[rd_ptr_q] : 32'h0;
  assign pd_bd   = pd_valid ? bd_mem_q[rd_ptr_q]   : 1'b0;
  assign pd_jump = pd_valid ? jump_mem_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_pd_stage.sv
// Scoreboard bench for pd_stage: a queue-based model predicts each head entry,
// a negedge monitor compares the DUT head against it and retires popped entries.
module tb_pd_stage;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset, if_valid, stall, refresh;
  logic [31:0] if_pc, if_inst;
  logic        if_ready, pd_valid, pd_bd, pd_jump;
  logic [31:0] pd_pc, pd_inst;

  pd_stage #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .stall    (stall),
    .refresh  (refresh),
    .pd_valid (pd_valid),
    .pd_pc    (pd_pc),
    .pd_inst  (pd_inst),
    .pd_bd    (pd_bd),
    .pd_jump  (pd_jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        bd;
    logic        jump;
  } entry_t;

  entry_t exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     mon_pops = 0;
  int     model_pops_seen = 0;
  logic   mon_en = 1'b0;
  logic   model_pushed = 1'b0;
  logic   model_last_jump = 1'b0;

  function automatic logic ref_jump(input logic [31:0] inst);
    int op, rt, fn;
    op = int'(inst[31:26]);
    rt = int'(inst[20:16]);
    fn = int'(inst[5:0]);
    return (op >= 2 && op <= 7) ||
           (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)) ||
           (op == 0 && (fn == 8 || fn == 9));
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int rts[4];
    rts = '{0, 1, 16, 17};
    w = $urandom;
    case ($urandom_range(0, 5))
      0: ;
      1: w[31:26] = 6'($urandom_range(2, 7));
      2: begin
        w[31:26] = 6'd1;
        if ($urandom_range(0, 1) == 0) w[20:16] = 5'(rts[$urandom_range(0, 3)]);
      end
      3: begin
        w[31:26] = 6'd0;
        w[5:0]   = 6'($urandom_range(8, 9));
      end
      4: w = 32'h0;
      default: w[31:26] = 6'd0;
    endcase
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: applies push/flush rules at each edge from the driven inputs.
  always @(posedge clk) begin
    int pre;
    pre = exp_q.size() + (mon_pops - model_pops_seen);
    model_pops_seen = mon_pops;
    model_pushed = 1'b0;
    if (reset) begin
      exp_q.delete();
      model_last_jump = 1'b0;
      mon_en = 1'b1;
    end else if (mon_en) begin
      if (refresh) begin
        exp_q.delete();
        model_last_jump = 1'b0;
      end else if (if_valid && pre != DEPTH) begin
        exp_q.push_back('{pc: if_pc, inst: if_inst, bd: model_last_jump,
                          jump: ref_jump(if_inst)});
        model_last_jump = ref_jump(if_inst);
        model_pushed = 1'b1;
      end
    end
  end

  // Monitor: compares the presented head, then retires it if the next edge pops.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("if_ready", 32'(if_ready), 32'(exp_q.size() != DEPTH));
      if (exp_q.size() == 0) begin
        check("empty_valid", 32'(pd_valid), 32'h0);
        check("empty_fields", {pd_pc[31:2], pd_bd, pd_jump} | pd_inst | 32'(pd_pc[1:0]),
              32'h0);
      end else begin
        check("pd_valid", 32'(pd_valid), 32'h1);
        check("pd_pc", pd_pc, exp_q[0].pc);
        check("pd_inst", pd_inst, exp_q[0].inst);
        check("pd_bd", 32'(pd_bd), 32'(exp_q[0].bd));
        check("pd_jump", 32'(pd_jump), 32'(exp_q[0].jump));
        if (!stall && !refresh) begin
          void'(exp_q.pop_front());
          mon_pops++;
        end
      end
    end
  end

  task automatic present(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic st, input logic rf, input logic rs);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    stall    = st;
    refresh  = rf;
    reset    = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic st);
    present(1'b0, 32'h0, 32'h0, st, 1'b0, 1'b0);
  endtask

  // Fetch-like push: hold the word until the queue accepts it.
  task automatic push_held(input logic [31:0] pc, input logic [31:0] inst, input logic st);
    int n;
    n = 0;
    do begin
      present(1'b1, pc, inst, st, 1'b0, 1'b0);
      n++;
    end while (!model_pushed && n < 64);
    checks++;
    if (!model_pushed) begin
      failures++;
      $display("FAIL push_timeout pc=%h not accepted within 64 cycles", pc);
    end
  endtask

  // Park inputs idle (stalled) and sample outputs at the next negedge.
  task automatic park_to_negedge();
    if_valid = 1'b0;
    stall    = 1'b1;
    refresh  = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
  endtask

  task automatic resume();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] cur_pc, cur_inst;
    logic        have, v, st, rf, rs;
    reset = 1'b1; if_valid = 1'b0; stall = 1'b0; refresh = 1'b0;
    if_pc = 32'h0; if_inst = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_pd_valid", 32'(pd_valid), 32'h0);
    check("rst_pd_pc", pd_pc, 32'h0);
    check("rst_pd_inst", pd_inst, 32'h0);
    check("rst_pd_bd", 32'(pd_bd), 32'h0);
    check("rst_pd_jump", 32'(pd_jump), 32'h0);
    check("rst_if_ready", 32'(if_ready), 32'h1);
    resume();

    // Single push, visible one cycle later.
    present(1'b1, 32'hBFC00000, 32'h24080001, 1'b1, 1'b0, 1'b0);
    park_to_negedge();
    check("first_valid", 32'(pd_valid), 32'h1);
    check("first_pc", pd_pc, 32'hBFC00000);
    check("first_jump", 32'(pd_jump), 32'h0);
    check("first_bd", 32'(pd_bd), 32'h0);
    resume();
    repeat (2) idle(1'b0);

    // Branch followed by its delay slot.
    present(1'b1, 32'h100, 32'h11000003, 1'b0, 1'b0, 1'b0);
    present(1'b1, 32'h104, 32'h00000000, 1'b0, 1'b0, 1'b0);
    park_to_negedge();
    check("slot_pc", pd_pc, 32'h104);
    check("slot_bd", 32'(pd_bd), 32'h1);
    check("slot_jump", 32'(pd_jump), 32'h0);
    resume();
    repeat (2) idle(1'b0);

    // Fill under stall; fifth word held until a slot frees.
    for (int i = 0; i < 4; i++) push_held(32'h200 + 32'(4 * i), rand_inst(), 1'b1);
    repeat (3) present(1'b1, 32'h210, 32'h0000000C, 1'b1, 1'b0, 1'b0);
    park_to_negedge();
    check("full_if_ready", 32'(if_ready), 32'h0);
    check("full_head_pc", pd_pc, 32'h200);
    resume();
    push_held(32'h210, 32'h0000000C, 1'b0);
    repeat (6) idle(1'b0);

    // Refresh after a JR clears queue and delay-slot tracking.
    push_held(32'h300, rand_inst(), 1'b1);
    push_held(32'h304, rand_inst(), 1'b1);
    push_held(32'h308, 32'h03E00008, 1'b1);
    present(1'b1, 32'h30C, 32'h0, 1'b0, 1'b1, 1'b0);
    park_to_negedge();
    check("refresh_valid", 32'(pd_valid), 32'h0);
    check("refresh_ready", 32'(if_ready), 32'h1);
    resume();
    push_held(32'h400, 32'h0, 1'b1);
    park_to_negedge();
    check("post_refresh_bd", 32'(pd_bd), 32'h0);
    resume();
    repeat (3) idle(1'b0);

    // Full queue, pop-only cycle.
    for (int i = 0; i < 4; i++) push_held(32'h500 + 32'(4 * i), rand_inst(), 1'b1);
    present(1'b1, 32'h510, 32'h0, 1'b0, 1'b0, 1'b0);
    park_to_negedge();
    check("pop_only_ready", 32'(if_ready), 32'h1);
    check("pop_only_head", pd_pc, 32'h504);
    resume();
    repeat (5) idle(1'b0);

    // Reset mid-stream with refresh, push and pop all active.
    push_held(32'h600, 32'h08000000, 1'b1);
    push_held(32'h604, rand_inst(), 1'b1);
    present(1'b1, 32'h608, 32'h0, 1'b0, 1'b1, 1'b1);
    park_to_negedge();
    check("mid_rst_valid", 32'(pd_valid), 32'h0);
    check("mid_rst_pc", pd_pc, 32'h0);
    check("mid_rst_inst", pd_inst, 32'h0);
    check("mid_rst_bd", 32'(pd_bd), 32'h0);
    check("mid_rst_jump", 32'(pd_jump), 32'h0);
    check("mid_rst_ready", 32'(if_ready), 32'h1);
    resume();

    // Randomized traffic with alternating stall pressure.
    have = 1'b0;
    cur_pc = 32'h0;
    cur_inst = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (!have) begin
        cur_pc   = $urandom;
        cur_inst = rand_inst();
      end
      v  = have || ($urandom_range(0, 3) != 0);
      st = ((c / 200) % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
      rf = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 149) == 0);
      present(v, cur_pc, cur_inst, st, rf, rs);
      have = v && !model_pushed && !rf && !rs;
    end
    repeat (8) idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
